fifo_stim_engine: RTL and testbench
===================================

// Module: fifo_stim_engine
// PURPOSE
//  Synthesizable, multi-channel FIFO stimulus engine; successor to the single-channel bench generator.
//  Drives NUM_CH FIFO push ports (valid/data, gated by grant_out) and their drain grants (grant_in).
//  Runs a fixed phase program (FILL, DRAIN, RUN@50%, RUN@100%, DRAIN) with LFSR payloads and even parity.
//  Sits between the test controller and the FIFO-with-parity-checker instances (FPGA/emulation and sim).
// PARAMETERS
//  DATA_WIDTH  17       word width; bit DATA_WIDTH-1 = even parity of bits [DATA_WIDTH-2:0]
//  FIFO_DEPTH  4        words per channel in FILL; cycles spent in DRAIN
//  NUM_CH      2        independent channels, 1..8
//  LFSR_SEED   16'hACE1 base seed; channel c is seeded with LFSR_SEED ^ c (never all-zero)
// PORTS
//  clk         in   1                    single clock, rising edge
//  rst_n       in   1                    asynchronous active-low reset
//  start_i     in   1                    1-cycle pulse, launches program; ignored while busy_o
//  abort_i     in   1                    forces IDLE next cycle; has priority over all else
//  run_cycles_i in  16                   length of each RUN phase in cycles, sampled at start
//  grant_out_i in   NUM_CH               FIFO push permission per channel
//  valid_o     out  NUM_CH               push request per channel
//  data_o      out  NUM_CH*DATA_WIDTH    payload, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//  grant_in_o  out  NUM_CH               FIFO pop permission (bandwidth pattern)
//  phase_o     out  3                    current phase_e
//  sent_cnt_o  out  NUM_CH*16            accepted words per channel, saturating at 16'hFFFF
//  busy_o      out  1                    high whenever phase_o != IDLE
//  done_o      out  1                    1-cycle pulse on DRAIN2 -> IDLE
// BEHAVIOUR
//  Reset: all outputs 0, phase IDLE, counters 0, LFSRs reseeded.
//  Transfer: channel c accepts on a rising edge where valid_o[c] && grant_out_i[c].
//   data_o is held stable while valid_o is high; LFSR steps only on transfer.
//  Phases:
//   IDLE -> FILL on start_i; sent_cnt_o cleared.
//   FILL: grant_in_o = 0; each channel pushes FIFO_DEPTH words, then drops valid.
//    Waits indefinitely for grant_out_i. Goes to DRAIN1 when all channels are complete.
//   DRAIN1: valid_o = 0, grant_in_o = all 1 for FIFO_DEPTH cycles, then RUN50.
//   RUN50: valid_o held high; grant_in_o toggles every cycle (1 on the first cycle).
//    Lasts run_cycles_i cycles, then RUN100.
//   RUN100: as RUN50 but grant_in_o = all 1, then DRAIN2.
//   DRAIN2: as DRAIN1, then IDLE with done_o.
//  Latency: start_i to first valid_o = 1 cycle (registered).
//  RUN timeout with a pending word: valid_o drops on the next cycle.
//   The untransferred word is not counted and its LFSR state is kept for the next transfer.
//  run_cycles_i = 0: the RUN phase lasts 0 cycles (pass straight through).
//  abort_i: valid_o and grant_in_o = 0 and phase IDLE on the next cycle; no done_o; counters kept.
//  Reset mid-phase: immediate return to reset values.
//  Parity: data_o[DW-1] = ^data_o[DW-2:0]. Payload = LFSR bits zero-extended or truncated to DW-1.
// CONFIGURATION
//  FIFO_STIM_PERR_INJ_EN defined:
//   Every 8th accepted word per channel (cnt%8 == 7) carries an inverted parity bit.
//   Adds output perr_inj_o [NUM_CH], a 1-cycle pulse on that transfer.
//  Not defined: parity is always correct and the perr_inj_o port does not exist.
// STRUCTURE
//  Package fifo_tb_pkg gains:
//   phase_e {IDLE, FILL, DRAIN1, RUN50, RUN100, DRAIN2}
//   the existing grant_in_e {BW_000, BW_050, BW_100}
//   LFSR_POLY constant 16'hB400 (Galois, x^16+x^14+x^13+x^11+1)
//  Sub-module stim_channel (one per channel, generate loop) holds:
//   the LFSR, the valid/data hold register, sent_cnt, the fill counter, parity and injection logic.
//  Top level holds the phase FSM, the cycle counter and grant_in pattern generation.
// TESTING
//  1 Reset:
//   assert rst_n=0 mid-RUN50 -> next sample shows valid_o=0, grant_in_o=0, phase=IDLE, sent_cnt=0.
//  2 FILL, NUM_CH=2, grant_out_i=2'b11:
//   exactly 4 transfers per channel, grant_in_o=0 throughout, then DRAIN1 lasts 4 cycles.
//  3 Backpressure, ch0 grant_out low 10 cycles:
//   ch0 data_o stable while valid is high, ch1 completes FILL, FSM stays in FILL until ch0 reaches 4.
//  4 Full run, run_cycles_i=20, grant_out=1:
//   RUN50 grant_in pattern 1010..., 20 cycles; RUN100 all 1s; done_o pulses once.
//   sent_cnt = 4+20+20 per channel; all words pass the parity check.
//  5 Abort at cycle 5 of RUN100:
//   valid_o=0 next cycle, no done_o; start_i restarts a clean FILL with sent_cnt cleared.
//  6 With FIFO_STIM_PERR_INJ_EN:
//   words 8, 16, 24 on each channel have bad parity and perr_inj_o pulses with them;
//   without the macro, zero parity errors.

Source files
------------

// File: rtl/fifo_stim_engine_pkg.sv
// Shared types and constants for the multi-channel FIFO stimulus engine.
// Optional feature macro used by the engine: FIFO_STIM_PERR_INJ_EN (parity error injection).
package fifo_tb_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FILL   = 3'd1,
      DRAIN1 = 3'd2,
      RUN50  = 3'd3,
      RUN100 = 3'd4,
      DRAIN2 = 3'd5
   } phase_e;

   typedef enum logic [1:0] {
      BW_000 = 2'd0,
      BW_050 = 2'd1,
      BW_100 = 2'd2
   } grant_in_e;

   // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
   localparam logic [15:0] LFSR_POLY = 16'hB400;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? LFSR_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/fifo_stim_engine_channel.sv
// One push channel: LFSR payload source, held valid/data, accepted-word and fill counters.
// FIFO_STIM_PERR_INJ_EN adds perr_inj_o and inverts parity on every 8th accepted word.
module stim_channel
   import fifo_tb_pkg::*;
#(
   parameter int          DATA_WIDTH = 17,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear_i,
   input  logic                  fill_en_i,
   input  logic                  run_en_i,
   input  logic                  grant_out_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [15:0]           sent_cnt_o,
   output logic                  fill_done_o
`ifdef FIFO_STIM_PERR_INJ_EN
   ,
   output logic                  perr_inj_o
`endif
);

   localparam int FW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = DATA_WIDTH - 1;

   logic [15:0]   lfsr_q, lfsr_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [FW-1:0] fill_q, fill_d;
   logic          fire;
   logic          par_flip;
   logic [PW-1:0] payload;

   // Handshake: a word moves on a rising edge where valid_o && grant_out_i; until then
   // the word (payload and parity) is held unchanged and the LFSR does not advance.
   always_comb begin
      valid_o  = run_en_i | (fill_en_i & (fill_q != FW'(FIFO_DEPTH)));
      fire     = valid_o & grant_out_i;
      payload  = PW'(lfsr_q);
      par_flip = 1'b0;
`ifdef FIFO_STIM_PERR_INJ_EN
      // Word index taken from the pending count, so the parity bit stays stable while held.
      par_flip   = (cnt_q[2:0] == 3'b111);
      perr_inj_o = fire & par_flip;
`endif
      data_o = valid_o ? {(^payload) ^ par_flip, payload} : '0;

      fill_done_o = (fill_q == FW'(FIFO_DEPTH)) |
                    (fill_en_i & fire & (fill_q == FW'(FIFO_DEPTH - 1)));

      lfsr_d = fire ? lfsr_step(lfsr_q) : lfsr_q;

      cnt_d  = cnt_q;
      fill_d = fill_q;
      if (clear_i) begin
         cnt_d  = '0;
         fill_d = '0;
      end else if (fire) begin
         if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
         if (fill_en_i)         fill_d = fill_q + FW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= SEED;
         cnt_q  <= '0;
         fill_q <= '0;
      end else begin
         lfsr_q <= lfsr_d;
         cnt_q  <= cnt_d;
         fill_q <= fill_d;
      end
   end

   assign sent_cnt_o = cnt_q;

endmodule

// File: rtl/fifo_stim_engine.sv
// Multi-channel FIFO stimulus engine: phase FSM, phase cycle counter and grant_in pattern.
// FIFO_STIM_PERR_INJ_EN adds perr_inj_o and periodic parity error injection.
module fifo_stim_engine
   import fifo_tb_pkg::*;
#(
   parameter int          DATA_WIDTH = 17,
   parameter int          FIFO_DEPTH = 4,
   parameter int          NUM_CH     = 2,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start_i,
   input  logic                         abort_i,
   input  logic [15:0]                  run_cycles_i,
   input  logic [NUM_CH-1:0]            grant_out_i,
   output logic [NUM_CH-1:0]            valid_o,
   output logic [NUM_CH*DATA_WIDTH-1:0] data_o,
   output logic [NUM_CH-1:0]            grant_in_o,
   output logic [2:0]                   phase_o,
   output logic [NUM_CH*16-1:0]         sent_cnt_o,
   output logic                         busy_o,
   output logic                         done_o
`ifdef FIFO_STIM_PERR_INJ_EN
   ,
   output logic [NUM_CH-1:0]            perr_inj_o
`endif
);

   localparam logic [15:0] DRAIN_LAST = 16'(FIFO_DEPTH - 1);

   phase_e      phase_q, phase_d;
   logic [15:0] cyc_q, cyc_d;
   logic [15:0] run_q, run_d;
   logic        done_q, done_d;
   logic        clear;
   logic        fill_en, run_en;
   grant_in_e   bw;
   logic [NUM_CH-1:0] fill_done;

   always_comb begin
      phase_d = phase_q;
      cyc_d   = cyc_q + 16'd1;
      run_d   = run_q;
      done_d  = 1'b0;
      clear   = 1'b0;
      if (abort_i) begin
         phase_d = IDLE;
         cyc_d   = '0;
      end else begin
         case (phase_q)
            IDLE: begin
               cyc_d = '0;
               if (start_i) begin
                  phase_d = FILL;
                  clear   = 1'b1;
                  run_d   = run_cycles_i;
               end
            end
            FILL: begin
               cyc_d = '0;
               if (&fill_done) phase_d = DRAIN1;
            end
            DRAIN1: if (cyc_q == DRAIN_LAST) begin
               cyc_d   = '0;
               // A zero-length RUN skips both RUN phases.
               phase_d = (run_q == 16'd0) ? DRAIN2 : RUN50;
            end
            RUN50: if (cyc_q == run_q - 16'd1) begin
               cyc_d   = '0;
               phase_d = RUN100;
            end
            RUN100: if (cyc_q == run_q - 16'd1) begin
               cyc_d   = '0;
               phase_d = DRAIN2;
            end
            DRAIN2: if (cyc_q == DRAIN_LAST) begin
               cyc_d   = '0;
               phase_d = IDLE;
               done_d  = 1'b1;
            end
            default: phase_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= IDLE;
         cyc_q   <= '0;
         run_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         cyc_q   <= cyc_d;
         run_q   <= run_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      fill_en = (phase_q == FILL);
      run_en  = (phase_q == RUN50) || (phase_q == RUN100);
      case (phase_q)
         DRAIN1, DRAIN2, RUN100: bw = BW_100;
         RUN50:                  bw = BW_050;
         default:                bw = BW_000;
      endcase
      case (bw)
         BW_100:  grant_in_o = '1;
         BW_050:  grant_in_o = {NUM_CH{~cyc_q[0]}};
         default: grant_in_o = '0;
      endcase
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      stim_channel #(
         .DATA_WIDTH (DATA_WIDTH),
         .FIFO_DEPTH (FIFO_DEPTH),
         .SEED       (LFSR_SEED ^ 16'(c))
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .clear_i     (clear),
         .fill_en_i   (fill_en),
         .run_en_i    (run_en),
         .grant_out_i (grant_out_i[c]),
         .valid_o     (valid_o[c]),
         .data_o      (data_o[c*DATA_WIDTH +: DATA_WIDTH]),
         .sent_cnt_o  (sent_cnt_o[c*16 +: 16]),
         .fill_done_o (fill_done[c])
`ifdef FIFO_STIM_PERR_INJ_EN
         ,
         .perr_inj_o  (perr_inj_o[c])
`endif
      );
   end

   assign phase_o = phase_q;
   assign busy_o  = (phase_q != IDLE);
   assign done_o  = done_q;

endmodule

// File: tb/tb_fifo_stim_engine.sv
// Directed bench for fifo_stim_engine with a per-channel scoreboard and a free-running monitor.
// Build with FIFO_STIM_PERR_INJ_EN defined to exercise parity error injection.
module tb_fifo_stim_engine;
   import fifo_tb_pkg::*;

   localparam int DW  = 17;
   localparam int NCH = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start_i = 1'b0;
   logic              abort_i = 1'b0;
   logic [15:0]       run_cycles_i = '0;
   logic [NCH-1:0]    grant_out_i = '0;
   logic [NCH-1:0]    valid_o;
   logic [NCH*DW-1:0] data_o;
   logic [NCH-1:0]    grant_in_o;
   logic [2:0]        phase_o;
   logic [NCH*16-1:0] sent_cnt_o;
   logic              busy_o;
   logic              done_o;
`ifdef FIFO_STIM_PERR_INJ_EN
   logic [NCH-1:0]    perr_inj;
`endif

   fifo_stim_engine #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (4),
      .NUM_CH     (NCH),
      .LFSR_SEED  (16'hACE1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .abort_i      (abort_i),
      .run_cycles_i (run_cycles_i),
      .grant_out_i  (grant_out_i),
      .valid_o      (valid_o),
      .data_o       (data_o),
      .grant_in_o   (grant_in_o),
      .phase_o      (phase_o),
      .sent_cnt_o   (sent_cnt_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
`ifdef FIFO_STIM_PERR_INJ_EN
      ,
      .perr_inj_o   (perr_inj)
`endif
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int par_err_seen = 0;
   int exp_perr = 0;
   int gsplit = 0;

   logic [15:0] lfsr_m [NCH];
   int          mcnt [NCH];
   logic [DW:0] exp_q [NCH][$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected words: LFSR payload, even parity, inverted on every 8th word when injecting.
   task automatic push_run(input int n);
      logic [15:0] pl;
      logic        inj, par, fb;
      for (int c = 0; c < NCH; c++) begin
         mcnt[c] = 0;
         for (int k = 0; k < n; k++) begin
            pl  = lfsr_m[c];
            inj = 1'b0;
`ifdef FIFO_STIM_PERR_INJ_EN
            inj = ((mcnt[c] % 8) == 7);
`endif
            par = (^pl) ^ inj;
            exp_perr += int'(inj);
            exp_q[c].push_back({inj, par, pl});
            fb = lfsr_m[c][0];
            lfsr_m[c] = lfsr_m[c] >> 1;
            if (fb) lfsr_m[c] = lfsr_m[c] ^ 16'hB400;
            mcnt[c]++;
         end
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin : mon
      logic [DW-1:0] got;
      logic [DW:0]   e;
      if (rst_n) begin
         if (done_o) done_cnt++;
         for (int c = 0; c < NCH; c++) begin
            if (valid_o[c] && grant_out_i[c]) begin
               got = data_o[c*DW +: DW];
               if (^got) par_err_seen++;
               if (exp_q[c].size() == 0) begin
                  check($sformatf("ch%0d unexpected word %0h", c, got), 64'(exp_q[c].size()), 64'd1);
               end else begin
                  e = exp_q[c].pop_front();
                  check($sformatf("ch%0d data", c), 64'(got), 64'(e[DW-1:0]));
`ifdef FIFO_STIM_PERR_INJ_EN
                  check($sformatf("ch%0d perr_inj", c), 64'(perr_inj[c]), 64'(e[DW]));
`endif
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_prog(input logic [15:0] rc);
      run_cycles_i = rc;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
   endtask

   // Runs while the given phase is visible, recording length and output patterns.
   task automatic measure(input phase_e ph, output int n, output logic [63:0] gbits,
                          output logic [1:0] v_or, output logic [1:0] g_or);
      n = 0;
      gbits = '0;
      v_or = '0;
      g_or = '0;
      while (phase_o == ph && n < 200) begin
         if (n < 64) gbits[n] = grant_in_o[0];
         if (grant_in_o[1] != grant_in_o[0]) gsplit++;
         v_or |= valid_o;
         g_or |= grant_in_o;
         n++;
         step();
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin : drv
      int          n, bad;
      logic [63:0] gb;
      logic [1:0]  vo, go;
      logic [DW-1:0] d0;

      lfsr_m[0] = 16'hACE1;
      lfsr_m[1] = 16'hACE0;
      repeat (3) step();
      rst_n = 1'b1;
      step();

      // Reset state
      check("reset valid", 64'(valid_o), 64'd0);
      check("reset grant_in", 64'(grant_in_o), 64'd0);
      check("reset phase", 64'(phase_o), 64'(IDLE));
      check("reset busy", 64'(busy_o), 64'd0);
      check("reset sent_cnt", 64'(sent_cnt_o), 64'd0);
      check("reset data", 64'(data_o), 64'd0);

      // Full program, run_cycles = 20, always granted
      grant_out_i = 2'b11;
      push_run(44);
      start_prog(16'd20);
      check("start phase", 64'(phase_o), 64'(FILL));
      check("start valid", 64'(valid_o), 64'h3);
      check("first word ch0", 64'(data_o[DW-1:0]), 64'h0ACE1);
      check("first word ch1", 64'(data_o[2*DW-1:DW]), 64'h1ACE0);
      measure(FILL, n, gb, vo, go);
      check("fill cycles", 64'(n), 64'd4);
      check("fill grant_in", 64'(go), 64'd0);
      check("fill sent_cnt", 64'(sent_cnt_o), 64'h0004_0004);
      measure(DRAIN1, n, gb, vo, go);
      check("drain1 cycles", 64'(n), 64'd4);
      check("drain1 valid", 64'(vo), 64'd0);
      check("drain1 grant_in", gb, 64'hF);
      measure(RUN50, n, gb, vo, go);
      check("run50 cycles", 64'(n), 64'd20);
      check("run50 grant_in", gb, 64'h55555);
      measure(RUN100, n, gb, vo, go);
      check("run100 cycles", 64'(n), 64'd20);
      check("run100 grant_in", gb, 64'hFFFFF);
      measure(DRAIN2, n, gb, vo, go);
      check("drain2 cycles", 64'(n), 64'd4);
      check("drain2 valid", 64'(vo), 64'd0);
      check("end phase", 64'(phase_o), 64'(IDLE));
      step();
      check("done pulses run1", 64'(done_cnt), 64'd1);
      check("run1 sent_cnt", 64'(sent_cnt_o), 64'h002C_002C);

      // Backpressure on ch0, run_cycles = 0
      push_run(4);
      grant_out_i = 2'b10;
      start_prog(16'd0);
      d0 = data_o[DW-1:0];
      bad = 0;
      repeat (10) begin
         if (data_o[DW-1:0] !== d0 || !valid_o[0]) bad++;
         step();
      end
      check("bp ch0 hold", 64'(bad), 64'd0);
      check("bp phase", 64'(phase_o), 64'(FILL));
      check("bp valid", 64'(valid_o), 64'h1);
      check("bp sent_cnt", 64'(sent_cnt_o), 64'h0004_0000);
      grant_out_i = 2'b11;
      measure(FILL, n, gb, vo, go);
      check("bp fill rest", 64'(n), 64'd4);
      measure(DRAIN1, n, gb, vo, go);
      check("bp drain1 cycles", 64'(n), 64'd4);
      check("run0 skips run", 64'(phase_o), 64'(DRAIN2));
      measure(DRAIN2, n, gb, vo, go);
      check("bp drain2 cycles", 64'(n), 64'd4);
      step();
      check("done pulses run2", 64'(done_cnt), 64'd2);
      check("bp sent_cnt end", 64'(sent_cnt_o), 64'h0004_0004);

      // Abort in cycle 5 of RUN100
      push_run(28);
      start_prog(16'd20);
      measure(FILL, n, gb, vo, go);
      measure(DRAIN1, n, gb, vo, go);
      measure(RUN50, n, gb, vo, go);
      check("abort run50 cycles", 64'(n), 64'd20);
      repeat (4) step();
      check("abort pre phase", 64'(phase_o), 64'(RUN100));
      abort_i = 1'b1;
      grant_out_i = 2'b00;
      step();
      abort_i = 1'b0;
      check("abort valid", 64'(valid_o), 64'd0);
      check("abort grant_in", 64'(grant_in_o), 64'd0);
      check("abort phase", 64'(phase_o), 64'(IDLE));
      check("abort sent_cnt", 64'(sent_cnt_o), 64'h001C_001C);
      step();
      step();
      check("abort no done", 64'(done_cnt), 64'd2);

      // Restart after abort
      grant_out_i = 2'b11;
      push_run(4);
      start_prog(16'd0);
      check("restart sent_cnt", 64'(sent_cnt_o), 64'd0);
      check("restart phase", 64'(phase_o), 64'(FILL));
      measure(FILL, n, gb, vo, go);
      measure(DRAIN1, n, gb, vo, go);
      measure(DRAIN2, n, gb, vo, go);
      step();
      check("done pulses run4", 64'(done_cnt), 64'd3);
      check("restart sent_cnt end", 64'(sent_cnt_o), 64'h0004_0004);

      // Reset in the middle of RUN50
      push_run(7);
      start_prog(16'd20);
      measure(FILL, n, gb, vo, go);
      measure(DRAIN1, n, gb, vo, go);
      repeat (3) step();
      check("pre-reset phase", 64'(phase_o), 64'(RUN50));
      grant_out_i = 2'b00;
      rst_n = 1'b0;
      #2;
      check("midrst valid", 64'(valid_o), 64'd0);
      check("midrst grant_in", 64'(grant_in_o), 64'd0);
      check("midrst phase", 64'(phase_o), 64'(IDLE));
      check("midrst sent_cnt", 64'(sent_cnt_o), 64'd0);
      check("midrst words left", 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);
      lfsr_m[0] = 16'hACE1;
      lfsr_m[1] = 16'hACE0;
      step();
      step();
      rst_n = 1'b1;
      step();

      // Short run after reset: LFSRs back at their seeds
      grant_out_i = 2'b11;
      push_run(4);
      start_prog(16'd0);
      check("reseeded ch0", 64'(data_o[DW-1:0]), 64'h0ACE1);
      measure(FILL, n, gb, vo, go);
      measure(DRAIN1, n, gb, vo, go);
      measure(DRAIN2, n, gb, vo, go);
      step();
      step();

      check("ch0 words left", 64'(exp_q[0].size()), 64'd0);
      check("ch1 words left", 64'(exp_q[1].size()), 64'd0);
      check("grant_in channel split", 64'(gsplit), 64'd0);
      check("parity errors", 64'(par_err_seen), 64'(exp_perr));
      check("done pulses total", 64'(done_cnt), 64'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
